// File: rtl/alu_sequencer.sv
// Operand/opcode sequencer and execute stage: captures A, B and opcode on three
// successive state_change strobes, executes once, holds result. Optional MUL via `ALU_MUL_EN`.
module alu_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   data,
    input  logic               state_change,
    output logic [2:0]         phase,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               err,
    output logic               done
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t          state_q;
    logic [WIDTH-1:0] a_q, b_q, op_q;
    logic            sc_q;
    logic [W2-1:0]   result_q;
    logic            carry_q, zero_q, err_q, done_q;

    logic             strobe;
    logic [W2-1:0]    a_ext, b_ext, sum;
    logic [WIDTH-1:0] diff;
    logic [W2-1:0]    alu_res;
    logic             alu_carry, alu_err, alu_zero;

    // A level held for several cycles yields a single strobe on its first cycle.
    assign strobe = state_change & ~sc_q;

    assign a_ext = {{WIDTH{1'b0}}, a_q};
    assign b_ext = {{WIDTH{1'b0}}, b_q};
    assign sum   = a_ext + b_ext;
    assign diff  = a_q - b_q;

    // NOTE: every output of this block gets a default first so no latch is inferred
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op_q)
            WIDTH'(0): begin
                alu_res   = sum;
                alu_carry = sum[WIDTH];
            end
            WIDTH'(1): begin
                alu_res   = {{WIDTH{1'b0}}, diff};
                alu_carry = (a_q < b_q);
            end
            WIDTH'(2): alu_res = a_ext & b_ext;
            WIDTH'(3): alu_res = a_ext | b_ext;
            WIDTH'(4): alu_res = a_ext ^ b_ext;
            WIDTH'(5): alu_res = {{WIDTH{1'b0}}, ~a_q};
            WIDTH'(6): begin
                alu_res   = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], 1'b0};
                alu_carry = a_q[WIDTH-1];
            end
            WIDTH'(7): alu_res = {{WIDTH{1'b0}}, a_q >> 1};
`ifdef ALU_MUL_EN
            WIDTH'(8): alu_res = a_ext * b_ext;
`endif
            default:   alu_err = 1'b1;
        endcase
        alu_zero = ~alu_err & (alu_res == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sc_q     <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sc_q <= state_change;
            case (state_q)
                LOAD_A: if (strobe) begin
                    a_q     <= data;
                    state_q <= LOAD_B;
                end
                LOAD_B: if (strobe) begin
                    b_q     <= data;
                    state_q <= LOAD_OP;
                end
                LOAD_OP: if (strobe) begin
                    op_q    <= data;
                    state_q <= EXEC;
                end
                EXEC: begin
                    result_q <= alu_res;
                    carry_q  <= alu_carry;
                    zero_q   <= alu_zero;
                    err_q    <= alu_err;
                    done_q   <= 1'b1;
                    state_q  <= SHOW;
                end
                SHOW: if (strobe) begin
                    done_q  <= 1'b0;
                    state_q <= LOAD_A;
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    assign phase  = state_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign err    = err_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected results, a monitor
// pops and compares on each rising edge of done. Build with +define+ALU_MUL_EN to test MUL.
module tb_alu_sequencer;

    localparam int WIDTH = 4;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       e;
    } exp_t;

    logic               clk;
    logic               reset;
    logic [WIDTH-1:0]   data;
    logic               state_change;
    logic [2:0]         phase;
    logic [2*WIDTH-1:0] result;
    logic               carry, zero, err, done;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic done_prev = 1'b0;

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .state_change (state_change),
        .phase        (phase),
        .result       (result),
        .carry        (carry),
        .zero         (zero),
        .err          (err),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare the held result against the scoreboard when done rises.
    always @(negedge clk) begin
        if (done === 1'b1 && done_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("carry",  32'(carry),  32'(e.c));
                check("zero",   32'(zero),   32'(e.z));
                check("err",    32'(err),    32'(e.e));
            end
        end
        done_prev = done;
    end

    task automatic strobe(input logic [WIDTH-1:0] v);
        @(negedge clk);
        data = v;
        state_change = 1'b1;
        @(negedge clk);
        state_change = 1'b0;
    endtask

    task automatic run_seq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                           input logic [7:0] res, input logic c, input logic z, input logic e);
        exp_t x;
        strobe(a);
        check("phase_after_a", 32'(phase), 32'd1);
        strobe(b);
        check("phase_after_b", 32'(phase), 32'd2);
        x.res = res; x.c = c; x.z = z; x.e = e;
        exp_q.push_back(x);
        strobe(op);
        check("phase_exec", 32'(phase), 32'd3);
        check("done_in_exec", 32'(done), 32'd0);
        @(negedge clk);
        check("phase_show", 32'(phase), 32'd4);
        check("done_show", 32'(done), 32'd1);
        strobe(4'h9);
        check("phase_back_to_a", 32'(phase), 32'd0);
        check("done_cleared", 32'(done), 32'd0);
        check("result_held", 32'(result), 32'(res));
    endtask

    initial begin
        reset = 1'b0;
        data = '0;
        state_change = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phase",  32'(phase),  32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags",  32'({carry, zero, err, done}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_seq(4'hA, 4'h5, 4'h0, 8'h0F, 1'b0, 1'b0, 1'b0);
        run_seq(4'hF, 4'hF, 4'h0, 8'h1E, 1'b1, 1'b0, 1'b0);
        run_seq(4'h5, 4'hA, 4'h1, 8'h0B, 1'b1, 1'b0, 1'b0);

        // Held level in LOAD_A: one capture only.
        @(negedge clk);
        data = 4'h3;
        state_change = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data = 4'h7;
            check("held_phase", 32'(phase), 32'd1);
        end
        state_change = 1'b0;
        @(negedge clk);
        check("held_low_phase", 32'(phase), 32'd1);
        strobe(4'hC);
        check("held_then_b", 32'(phase), 32'd2);
        exp_q.push_back('{res: 8'h00, c: 1'b0, z: 1'b1, e: 1'b0});
        strobe(4'h2);
        @(negedge clk);
        check("and_phase_show", 32'(phase), 32'd4);
        strobe(4'h0);

`ifdef ALU_MUL_EN
        run_seq(4'hA, 4'h5, 4'h8, 8'h32, 1'b0, 1'b0, 1'b0);
`else
        run_seq(4'hA, 4'h5, 4'h8, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
        run_seq(4'hA, 4'h5, 4'hF, 8'h00, 1'b0, 1'b0, 1'b1);
        run_seq(4'hA, 4'h5, 4'h3, 8'h0F, 1'b0, 1'b0, 1'b0);
        run_seq(4'h6, 4'h3, 4'h4, 8'h05, 1'b0, 1'b0, 1'b0);
        run_seq(4'h5, 4'h0, 4'h5, 8'h0A, 1'b0, 1'b0, 1'b0);
        run_seq(4'h9, 4'h0, 4'h6, 8'h02, 1'b1, 1'b0, 1'b0);
        run_seq(4'h9, 4'h0, 4'h7, 8'h04, 1'b0, 1'b0, 1'b0);

        // Reset in LOAD_OP after A and B captured; result was nonzero before.
        strobe(4'hA);
        strobe(4'h5);
        check("pre_reset_phase", 32'(phase), 32'd2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_phase",  32'(phase),  32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags",  32'({carry, zero, err, done}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        data = 4'h3;
        state_change = 1'b1;
        @(negedge clk);
        state_change = 1'b0;
        check("first_edge_strobe", 32'(phase), 32'd1);
        strobe(4'h3);
        check("post_rst_b", 32'(phase), 32'd2);
        exp_q.push_back('{res: 8'h00, c: 1'b0, z: 1'b1, e: 1'b0});
        strobe(4'h4);
        @(negedge clk);
        check("post_rst_show", 32'(phase), 32'd4);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Operand/opcode sequencer and execute stage for the ALU lab design. Sits directly downstream of the `go` input-conditioning stage: consumes its 4-bit `data` bus and `state_change` strobe, captures operand A, operand B and opcode on three successive strobes, executes one operation, and holds the result and flags for display until the next strobe.

## Interface

Parameters:
- `WIDTH`, 4, operand and opcode width in bits; result is 2*WIDTH bits wide.

Ports:
- `clk`  input  1  system clock, all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `data`  input  WIDTH  operand/opcode value from the `go` stage.
- `state_change`  input  1  capture request from the `go` stage, treated as a level; rising-edge detected internally.
- `phase`  output  3  current FSM state code.
- `result`  output  2*WIDTH  registered ALU result.
- `carry`  output  1  carry out (ADD, SHL) or borrow (SUB).
- `zero`  output  1  result equals 0 on a valid op.
- `err`  output  1  last opcode was unsupported.
- `done`  output  1  high while result is being held.

## Operation

- Edge detect: `sc_q` registers `state_change`; strobe = `state_change & ~sc_q`. A level held N cycles produces exactly one strobe.
- FSM states and codes: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4.
  - LOAD_A: on strobe, A <= `data`, go to LOAD_B.
  - LOAD_B: on strobe, B <= `data`, go to LOAD_OP.
  - LOAD_OP: on strobe, OP <= `data`, go to EXEC.
  - EXEC: unconditional, one cycle; compute and register result and flags, go to SHOW. A strobe in EXEC is dropped.
  - SHOW: `done`=1; on strobe, clear `done`, go to LOAD_A; `data` of that strobe is discarded. `result` and flags hold until the next EXEC.
- Opcodes (OP value): 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHL A<<1; 7 SHR A>>1; 8 MUL (see Configuration); all others invalid.
- Width rules: operands zero-extended to 2*WIDTH. ADD result = WIDTH+1-bit sum, `carry` = sum bit WIDTH. SUB result = (A-B) mod 2^WIDTH, `carry` = (A<B). SHL result = (A<<1) mod 2^WIDTH, `carry` = A[WIDTH-1]. Logic ops and SHR: `carry`=0, upper WIDTH bits 0.
- `zero` = (result==0) for valid ops. Invalid op: `result`=0, `err`=1, `zero`=0, `carry`=0. Valid op clears `err`.

## Timing

- Reset (asserted low, any time): `phase`=0, `result`=0, `carry`=0, `zero`=0, `err`=0, `done`=0, A/B/OP=0, `sc_q`=0. Reset mid-sequence discards captured operands; first strobe after release captures A.
- Capture: `data` sampled on the same rising edge where strobe is high.
- Latency: OP captured at edge k; `phase`=3 after edge k; `result`/flags valid and `done`=1 after edge k+1.
- `state_change` high on the first edge after reset release is a strobe (`sc_q`=0 from reset).

## Configuration

- `ALU_MUL_EN`: defined -> OP 8 = unsigned A*B into full 2*WIDTH result, `carry`=0, `err`=0. Undefined -> no multiplier synthesized; OP 8 is invalid (`err`=1, `result`=0).

## Test plan

- Reset low then high -> all outputs 0, `phase`=0; strobe with `data`=4'hA -> `phase`=1.
- A=10, B=5, OP=0 -> two cycles after OP strobe `result`=8'h0F, `carry`=0, `zero`=0, `done`=1, `phase`=4.
- A=15, B=15, OP=0 -> `result`=8'h1E, `carry`=1; A=5, B=10, OP=1 -> `result`=8'h0B, `carry`=1.
- `state_change` held high 3 cycles in LOAD_A -> single capture, `phase`=1 only; next capture needs a low then high.
- A=10, B=5, OP=8 -> with `ALU_MUL_EN` `result`=8'h32, `err`=0; without, `result`=0, `err`=1; OP=4'hF -> `err`=1 in both builds.
- Reset pulsed low in LOAD_OP after A, B captured -> `phase`=0, `result` 0; new sequence A=3, B=3, OP=4 -> `result`=0, `zero`=1.
